// File: rtl/axi4_data_width_converter_32to64.sv
// AXI4 upsizer: 32-bit manager (in_*) to 64-bit subordinate (out_*).
// Read and write paths are independent. Each path allows one outstanding
// burst and tracks the per-beat address, so narrow beats land on the
// correct 32-bit lane of the 64-bit bus.
// Optional macro AXI4_UPSIZER_ZERO_FILL_EN: when defined, the inactive half
// of out_wdata is driven to zero; otherwise in_wdata is replicated on both halves.
module axi4_data_width_converter_32to64 #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   // 32-bit side, read address / data
   input  logic              in_arvalid,
   output logic              in_arready,
   input  logic [ID_W-1:0]   in_arid,
   input  logic [ADDR_W-1:0] in_araddr,
   input  logic [7:0]        in_arlen,
   input  logic [2:0]        in_arsize,
   input  logic [1:0]        in_arburst,
   output logic              in_rvalid,
   input  logic              in_rready,
   output logic [ID_W-1:0]   in_rid,
   output logic [31:0]       in_rdata,
   output logic [1:0]        in_rresp,
   output logic              in_rlast,
   // 32-bit side, write address / data / response
   input  logic              in_awvalid,
   output logic              in_awready,
   input  logic [ID_W-1:0]   in_awid,
   input  logic [ADDR_W-1:0] in_awaddr,
   input  logic [7:0]        in_awlen,
   input  logic [2:0]        in_awsize,
   input  logic [1:0]        in_awburst,
   input  logic              in_wvalid,
   output logic              in_wready,
   input  logic [31:0]       in_wdata,
   input  logic [3:0]        in_wstrb,
   input  logic              in_wlast,
   output logic              in_bvalid,
   input  logic              in_bready,
   output logic [ID_W-1:0]   in_bid,
   output logic [1:0]        in_bresp,
   // 64-bit side, read address / data
   output logic              out_arvalid,
   input  logic              out_arready,
   output logic [ID_W-1:0]   out_arid,
   output logic [ADDR_W-1:0] out_araddr,
   output logic [7:0]        out_arlen,
   output logic [2:0]        out_arsize,
   output logic [1:0]        out_arburst,
   input  logic              out_rvalid,
   output logic              out_rready,
   input  logic [ID_W-1:0]   out_rid,
   input  logic [63:0]       out_rdata,
   input  logic [1:0]        out_rresp,
   input  logic              out_rlast,
   // 64-bit side, write address / data / response
   output logic              out_awvalid,
   input  logic              out_awready,
   output logic [ID_W-1:0]   out_awid,
   output logic [ADDR_W-1:0] out_awaddr,
   output logic [7:0]        out_awlen,
   output logic [2:0]        out_awsize,
   output logic [1:0]        out_awburst,
   output logic              out_wvalid,
   input  logic              out_wready,
   output logic [63:0]       out_wdata,
   output logic [7:0]        out_wstrb,
   output logic              out_wlast,
   input  logic              out_bvalid,
   output logic              out_bready,
   input  logic [ID_W-1:0]   out_bid,
   input  logic [1:0]        out_bresp
);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_t;

   localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

   // The 32-bit manager can never carry more than 4 bytes per beat.
   function automatic logic [2:0] clamp_size(input logic [2:0] size);
      return (size > 3'd2) ? 3'd2 : size;
   endfunction

   // Address of the following beat; WRAP stays inside the (len+1)<<size window.
   function automatic logic [ADDR_W-1:0] next_beat_addr(
      input logic [ADDR_W-1:0] addr,
      input logic [7:0]        len,
      input logic [2:0]        size,
      input logic [1:0]        burst
   );
      logic [ADDR_W-1:0] incr;
      logic [ADDR_W-1:0] mask;
      incr = ONE_A << size;
      mask = (((ADDR_W)'(len) + ONE_A) << size) - ONE_A;
      case (burst)
         2'b00:   return addr;
         2'b01:   return addr + incr;
         2'b10:   return (addr & ~mask) | ((addr + incr) & mask);
         default: return addr;
      endcase
   endfunction

   r_state_t          r_state_r;
   logic              in_arready_r;
   logic              out_arvalid_r;
   logic [ID_W-1:0]   ar_id_r;
   logic [ADDR_W-1:0] ar_addr_r;
   logic [7:0]        ar_len_r;
   logic [2:0]        ar_size_r;
   logic [1:0]        ar_burst_r;
   logic [ADDR_W-1:0] r_beat_r;

   w_state_t          w_state_r;
   logic              in_awready_r;
   logic              out_awvalid_r;
   logic [ID_W-1:0]   aw_id_r;
   logic [ADDR_W-1:0] aw_addr_r;
   logic [7:0]        aw_len_r;
   logic [2:0]        aw_size_r;
   logic [1:0]        aw_burst_r;
   logic [ADDR_W-1:0] w_beat_r;

   assign in_arready  = in_arready_r;
   assign out_arvalid = out_arvalid_r;
   assign out_arid    = ar_id_r;
   assign out_araddr  = ar_addr_r;
   assign out_arlen   = ar_len_r;
   assign out_arsize  = ar_size_r;
   assign out_arburst = ar_burst_r;
   assign in_awready  = in_awready_r;
   assign out_awvalid = out_awvalid_r;
   assign out_awid    = aw_id_r;
   assign out_awaddr  = aw_addr_r;
   assign out_awlen   = aw_len_r;
   assign out_awsize  = aw_size_r;
   assign out_awburst = aw_burst_r;

   // Read FSM: capture AR, issue it on the 64-bit side, then track beats until rlast.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state_r     <= R_IDLE;
         in_arready_r  <= 1'b1;
         out_arvalid_r <= 1'b0;
         ar_id_r       <= '0;
         ar_addr_r     <= '0;
         ar_len_r      <= 8'd0;
         ar_size_r     <= 3'd0;
         ar_burst_r    <= 2'b00;
         r_beat_r      <= '0;
      end else begin
         case (r_state_r)
            R_IDLE: if (in_arvalid) begin
               ar_id_r       <= in_arid;
               ar_addr_r     <= in_araddr;
               ar_len_r      <= in_arlen;
               ar_size_r     <= clamp_size(in_arsize);
               ar_burst_r    <= in_arburst;
               r_beat_r      <= in_araddr;
               in_arready_r  <= 1'b0;
               out_arvalid_r <= 1'b1;
               r_state_r     <= R_ADDR;
            end
            R_ADDR: if (out_arready) begin
               out_arvalid_r <= 1'b0;
               r_state_r     <= R_DATA;
            end
            R_DATA: if (out_rvalid && in_rready) begin
               r_beat_r <= next_beat_addr(r_beat_r, ar_len_r, ar_size_r, ar_burst_r);
               if (out_rlast) begin
                  in_arready_r <= 1'b1;
                  r_state_r    <= R_IDLE;
               end
            end
            default: begin
               in_arready_r  <= 1'b1;
               out_arvalid_r <= 1'b0;
               r_state_r     <= R_IDLE;
            end
         endcase
      end
   end

   // Read data path: zero-latency pass-through with lane select by beat address.
   always_comb begin
      if (r_state_r == R_DATA) begin
         in_rvalid  = out_rvalid;
         out_rready = in_rready;
         in_rid     = out_rid;
         in_rdata   = r_beat_r[2] ? out_rdata[63:32] : out_rdata[31:0];
         in_rresp   = out_rresp;
         in_rlast   = out_rlast;
      end else begin
         in_rvalid  = 1'b0;
         out_rready = 1'b0;
         in_rid     = '0;
         in_rdata   = 32'h0000_0000;
         in_rresp   = 2'b00;
         in_rlast   = 1'b0;
      end
   end

   // Write FSM: capture AW, issue it, steer W beats, then wait for the B handshake.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         w_state_r     <= W_IDLE;
         in_awready_r  <= 1'b1;
         out_awvalid_r <= 1'b0;
         aw_id_r       <= '0;
         aw_addr_r     <= '0;
         aw_len_r      <= 8'd0;
         aw_size_r     <= 3'd0;
         aw_burst_r    <= 2'b00;
         w_beat_r      <= '0;
      end else begin
         case (w_state_r)
            W_IDLE: if (in_awvalid) begin
               aw_id_r       <= in_awid;
               aw_addr_r     <= in_awaddr;
               aw_len_r      <= in_awlen;
               aw_size_r     <= clamp_size(in_awsize);
               aw_burst_r    <= in_awburst;
               w_beat_r      <= in_awaddr;
               in_awready_r  <= 1'b0;
               out_awvalid_r <= 1'b1;
               w_state_r     <= W_ADDR;
            end
            W_ADDR: if (out_awready) begin
               out_awvalid_r <= 1'b0;
               w_state_r     <= W_DATA;
            end
            W_DATA: if (in_wvalid && out_wready) begin
               w_beat_r <= next_beat_addr(w_beat_r, aw_len_r, aw_size_r, aw_burst_r);
               if (in_wlast) begin
                  w_state_r <= W_RESP;
               end
            end
            W_RESP: if (out_bvalid && in_bready) begin
               in_awready_r <= 1'b1;
               w_state_r    <= W_IDLE;
            end
            default: begin
               in_awready_r  <= 1'b1;
               out_awvalid_r <= 1'b0;
               w_state_r     <= W_IDLE;
            end
         endcase
      end
   end

   // Write data path: lane steering of strobes and data during the data phase.
   always_comb begin
      if (w_state_r == W_DATA) begin
         in_wready  = out_wready;
         out_wvalid = in_wvalid;
         out_wstrb  = w_beat_r[2] ? {in_wstrb, 4'b0000} : {4'b0000, in_wstrb};
`ifdef AXI4_UPSIZER_ZERO_FILL_EN
         out_wdata  = w_beat_r[2] ? {in_wdata, 32'h0000_0000} : {32'h0000_0000, in_wdata};
`else
         out_wdata  = {in_wdata, in_wdata};
`endif
         out_wlast  = in_wlast;
      end else begin
         in_wready  = 1'b0;
         out_wvalid = 1'b0;
         out_wstrb  = 8'h00;
         out_wdata  = 64'h0;
         out_wlast  = 1'b0;
      end
   end

   // Write response path: pass-through only while waiting for B.
   always_comb begin
      if (w_state_r == W_RESP) begin
         in_bvalid  = out_bvalid;
         out_bready = in_bready;
         in_bid     = out_bid;
         in_bresp   = out_bresp;
      end else begin
         in_bvalid  = 1'b0;
         out_bready = 1'b0;
         in_bid     = '0;
         in_bresp   = 2'b00;
      end
   end

endmodule

// File: tb/tb_axi4_data_width_converter_32to64.sv
// Directed testbench for axi4_data_width_converter_32to64.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_axi4_data_width_converter_32to64;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
`ifdef AXI4_UPSIZER_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic clock, reset;
   logic in_arvalid, in_arready; logic [ID_W-1:0] in_arid; logic [ADDR_W-1:0] in_araddr;
   logic [7:0] in_arlen; logic [2:0] in_arsize; logic [1:0] in_arburst;
   logic in_rvalid, in_rready; logic [ID_W-1:0] in_rid; logic [31:0] in_rdata;
   logic [1:0] in_rresp; logic in_rlast;
   logic in_awvalid, in_awready; logic [ID_W-1:0] in_awid; logic [ADDR_W-1:0] in_awaddr;
   logic [7:0] in_awlen; logic [2:0] in_awsize; logic [1:0] in_awburst;
   logic in_wvalid, in_wready; logic [31:0] in_wdata; logic [3:0] in_wstrb; logic in_wlast;
   logic in_bvalid, in_bready; logic [ID_W-1:0] in_bid; logic [1:0] in_bresp;
   logic out_arvalid, out_arready; logic [ID_W-1:0] out_arid; logic [ADDR_W-1:0] out_araddr;
   logic [7:0] out_arlen; logic [2:0] out_arsize; logic [1:0] out_arburst;
   logic out_rvalid, out_rready; logic [ID_W-1:0] out_rid; logic [63:0] out_rdata;
   logic [1:0] out_rresp; logic out_rlast;
   logic out_awvalid, out_awready; logic [ID_W-1:0] out_awid; logic [ADDR_W-1:0] out_awaddr;
   logic [7:0] out_awlen; logic [2:0] out_awsize; logic [1:0] out_awburst;
   logic out_wvalid, out_wready; logic [63:0] out_wdata; logic [7:0] out_wstrb; logic out_wlast;
   logic out_bvalid, out_bready; logic [ID_W-1:0] out_bid; logic [1:0] out_bresp;

   int checks = 0;
   int errors = 0;

   axi4_data_width_converter_32to64 #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset),
      .in_arvalid(in_arvalid), .in_arready(in_arready), .in_arid(in_arid), .in_araddr(in_araddr),
      .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
      .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rid(in_rid), .in_rdata(in_rdata),
      .in_rresp(in_rresp), .in_rlast(in_rlast),
      .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awid(in_awid), .in_awaddr(in_awaddr),
      .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awburst(in_awburst),
      .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
      .in_wlast(in_wlast),
      .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bid(in_bid), .in_bresp(in_bresp),
      .out_arvalid(out_arvalid), .out_arready(out_arready), .out_arid(out_arid),
      .out_araddr(out_araddr), .out_arlen(out_arlen), .out_arsize(out_arsize),
      .out_arburst(out_arburst),
      .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rid(out_rid), .out_rdata(out_rdata),
      .out_rresp(out_rresp), .out_rlast(out_rlast),
      .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awid(out_awid),
      .out_awaddr(out_awaddr), .out_awlen(out_awlen), .out_awsize(out_awsize),
      .out_awburst(out_awburst),
      .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata),
      .out_wstrb(out_wstrb), .out_wlast(out_wlast),
      .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bid(out_bid), .out_bresp(out_bresp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Present an AR, then grant it on the 64-bit side; returns in the data phase.
   task automatic issue_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      @(negedge clock);
      in_arvalid = 1'b1; in_arid = id; in_araddr = addr;
      in_arlen = len; in_arsize = size; in_arburst = burst;
      @(negedge clock);
      in_arvalid = 1'b0; out_arready = 1'b1;
      @(negedge clock);
      out_arready = 1'b0;
   endtask

   // Present an AW, then grant it on the 64-bit side; returns in the data phase.
   task automatic issue_aw(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      @(negedge clock);
      in_awvalid = 1'b1; in_awid = id; in_awaddr = addr;
      in_awlen = len; in_awsize = size; in_awburst = burst;
      @(negedge clock);
      in_awvalid = 1'b0; out_awready = 1'b1;
      @(negedge clock);
      out_awready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_arvalid = 1'b0; in_arid = '0; in_araddr = '0; in_arlen = 8'd0; in_arsize = 3'd0;
      in_arburst = 2'b01; in_rready = 1'b0;
      in_awvalid = 1'b0; in_awid = '0; in_awaddr = '0; in_awlen = 8'd0; in_awsize = 3'd0;
      in_awburst = 2'b01; in_wvalid = 1'b0; in_wdata = 32'h0; in_wstrb = 4'h0; in_wlast = 1'b0;
      in_bready = 1'b0;
      out_arready = 1'b0; out_rvalid = 1'b0; out_rid = '0; out_rdata = 64'h0;
      out_rresp = 2'b00; out_rlast = 1'b0;
      out_awready = 1'b0; out_wready = 1'b0; out_bvalid = 1'b0; out_bid = '0; out_bresp = 2'b00;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if ({in_arready, in_awready, out_arvalid, out_awvalid, in_rvalid, in_wready, in_bvalid}
          !== 7'b1100000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 1100000",
                  {in_arready, in_awready, out_arvalid, out_awvalid, in_rvalid, in_wready, in_bvalid});
      end
      checks++;
      if (out_araddr !== 32'h0 || out_awaddr !== 32'h0 || out_wdata !== 64'h0) begin
         errors++;
         $display("FAIL reset_payload: araddr=%h awaddr=%h wdata=%h expected zeros",
                  out_araddr, out_awaddr, out_wdata);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      @(negedge clock);
      in_arvalid = 1'b1; in_arid = 4'd3; in_araddr = 32'h8000_0004;
      in_arlen = 8'd0; in_arsize = 3'd2; in_arburst = 2'b01;
      @(negedge clock);
      in_arvalid = 1'b0;
      #1;
      checks++;
      if (out_arvalid !== 1'b1 || out_araddr !== 32'h8000_0004 || out_arid !== 4'd3
          || out_arlen !== 8'd0 || in_arready !== 1'b0) begin
         errors++;
         $display("FAIL single_read_ar: valid=%b addr=%h id=%h len=%h rdy=%b expected 1 80000004 3 00 0",
                  out_arvalid, out_araddr, out_arid, out_arlen, in_arready);
      end
      out_arready = 1'b1;
      @(negedge clock);
      out_arready = 1'b0;
      out_rvalid = 1'b1; out_rdata = 64'h1111_2222_3333_4444; out_rlast = 1'b1;
      out_rid = 4'd3; out_rresp = 2'b00; in_rready = 1'b1;
      #1;
      checks++;
      if (in_rvalid !== 1'b1 || in_rdata !== 32'h1111_2222 || in_rlast !== 1'b1
          || in_rid !== 4'd3 || out_rready !== 1'b1) begin
         errors++;
         $display("FAIL single_read_r: valid=%b data=%h last=%b id=%h rready=%b expected 1 11112222 1 3 1",
                  in_rvalid, in_rdata, in_rlast, in_rid, out_rready);
      end
      @(negedge clock);
      out_rvalid = 1'b0; out_rlast = 1'b0;
      #1;
      checks++;
      if (in_arready !== 1'b1) begin
         errors++;
         $display("FAIL single_read_done: in_arready=%b expected 1", in_arready);
      end
   endtask

   task automatic test_incr_read();
      logic [31:0] exp_data;
      issue_ar(4'd1, 32'h0, 8'd3, 3'd2, 2'b01);
      for (int i = 0; i < 4; i++) begin
         out_rvalid = 1'b1; out_rid = 4'd1; in_rready = 1'b1;
         out_rdata = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
         out_rlast = (i == 3);
         exp_data = (i % 2 == 1) ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i);
         #1;
         checks++;
         if (in_rdata !== exp_data || in_rlast !== (i == 3) || in_arready !== 1'b0) begin
            errors++;
            $display("FAIL incr_read_beat%0d: data=%h last=%b arready=%b expected %h %b 0",
                     i, in_rdata, in_rlast, in_arready, exp_data, (i == 3));
         end
         @(negedge clock);
      end
      out_rvalid = 1'b0; out_rlast = 1'b0;
      #1;
      checks++;
      if (in_arready !== 1'b1) begin
         errors++;
         $display("FAIL incr_read_done: in_arready=%b expected 1", in_arready);
      end
   endtask

   task automatic test_addr_wrap_and_fixed();
      // INCR from the top of the address space wraps to 0: high lane then low lane.
      issue_ar(4'd2, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
      for (int i = 0; i < 2; i++) begin
         out_rvalid = 1'b1; in_rready = 1'b1; out_rlast = (i == 1);
         out_rdata = 64'h6666_0000_7777_0000 + 64'(i);
         #1;
         checks++;
         if (in_rdata !== ((i == 0) ? 32'h6666_0000 : 32'h7777_0001)) begin
            errors++;
            $display("FAIL addr_wrap_beat%0d: data=%h expected %h", i, in_rdata,
                     (i == 0) ? 32'h6666_0000 : 32'h7777_0001);
         end
         @(negedge clock);
      end
      out_rvalid = 1'b0; out_rlast = 1'b0;
      // FIXED at 0x4: both beats stay on the high lane.
      issue_ar(4'd2, 32'h0000_0004, 8'd1, 3'd2, 2'b00);
      for (int i = 0; i < 2; i++) begin
         out_rvalid = 1'b1; in_rready = 1'b1; out_rlast = (i == 1);
         out_rdata = 64'h9999_0000_4444_0000 + 64'(i);
         #1;
         checks++;
         if (in_rdata !== 32'h9999_0000) begin
            errors++;
            $display("FAIL fixed_read_beat%0d: data=%h expected 99990000", i, in_rdata);
         end
         @(negedge clock);
      end
      out_rvalid = 1'b0; out_rlast = 1'b0;
   endtask

   task automatic test_single_write();
      logic [31:0] addrs [2];
      logic [7:0]  strbs [2];
      logic [63:0] exp_wdata;
      addrs[0] = 32'h10; addrs[1] = 32'h14;
      strbs[0] = 8'h0F;  strbs[1] = 8'hF0;
      // A W beat before AW must be stalled.
      @(negedge clock);
      in_wvalid = 1'b1; out_wready = 1'b1;
      #1;
      checks++;
      if (in_wready !== 1'b0 || out_wvalid !== 1'b0) begin
         errors++;
         $display("FAIL w_before_aw: wready=%b out_wvalid=%b expected 0 0", in_wready, out_wvalid);
      end
      in_wvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         issue_aw(4'd5, addrs[k], 8'd0, 3'd2, 2'b01);
         in_wvalid = 1'b1; in_wdata = 32'hDEAD_BEEF; in_wstrb = 4'hF; in_wlast = 1'b1;
         out_wready = 1'b1;
         if (ZF) exp_wdata = (k == 1) ? 64'hDEAD_BEEF_0000_0000 : 64'h0000_0000_DEAD_BEEF;
         else    exp_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
         #1;
         checks++;
         if (in_wready !== 1'b1 || out_wvalid !== 1'b1 || out_wstrb !== strbs[k]
             || out_wdata !== exp_wdata || out_wlast !== 1'b1 || out_awaddr !== addrs[k]) begin
            errors++;
            $display("FAIL single_write%0d_w: wready=%b wvalid=%b strb=%h data=%h last=%b awaddr=%h expected 1 1 %h %h 1 %h",
                     k, in_wready, out_wvalid, out_wstrb, out_wdata, out_wlast, out_awaddr,
                     strbs[k], exp_wdata, addrs[k]);
         end
         @(negedge clock);
         in_wvalid = 1'b0; in_wlast = 1'b0; out_wready = 1'b0;
         out_bvalid = 1'b1; out_bid = 4'd5; out_bresp = 2'b00; in_bready = 1'b1;
         #1;
         checks++;
         if (in_bvalid !== 1'b1 || in_bid !== 4'd5 || out_bready !== 1'b1 || in_wready !== 1'b0) begin
            errors++;
            $display("FAIL single_write%0d_b: bvalid=%b bid=%h bready=%b wready=%b expected 1 5 1 0",
                     k, in_bvalid, in_bid, out_bready, in_wready);
         end
         @(negedge clock);
         out_bvalid = 1'b0;
         #1;
         checks++;
         if (in_awready !== 1'b1) begin
            errors++;
            $display("FAIL single_write%0d_done: in_awready=%b expected 1", k, in_awready);
         end
      end
   endtask

   task automatic test_wrap_write();
      logic [7:0]  exp_strb [4];
      logic [63:0] exp_wdata;
      logic [31:0] d;
      exp_strb[0] = 8'h0F; exp_strb[1] = 8'hF0; exp_strb[2] = 8'h0F; exp_strb[3] = 8'hF0;
      issue_aw(4'd8, 32'h18, 8'd3, 3'd2, 2'b10);
      for (int i = 0; i < 4; i++) begin
         d = 32'hC0DE_0000 + 32'(i);
         in_wvalid = 1'b1; in_wdata = d; in_wstrb = 4'hF; in_wlast = (i == 3);
         out_wready = 1'b1;
         if (ZF) exp_wdata = (i % 2 == 1) ? {d, 32'h0000_0000} : {32'h0000_0000, d};
         else    exp_wdata = {d, d};
         #1;
         checks++;
         if (out_wstrb !== exp_strb[i] || out_wdata !== exp_wdata || out_wlast !== (i == 3)) begin
            errors++;
            $display("FAIL wrap_write_beat%0d: strb=%h data=%h last=%b expected %h %h %b",
                     i, out_wstrb, out_wdata, out_wlast, exp_strb[i], exp_wdata, (i == 3));
         end
         @(negedge clock);
      end
      in_wvalid = 1'b0; in_wlast = 1'b0; out_wready = 1'b0;
      out_bvalid = 1'b1; out_bid = 4'd8; out_bresp = 2'b10; in_bready = 1'b1;
      #1;
      checks++;
      if (in_bvalid !== 1'b1 || in_bresp !== 2'b10 || in_bid !== 4'd8) begin
         errors++;
         $display("FAIL wrap_write_b: bvalid=%b bresp=%b bid=%h expected 1 10 8",
                  in_bvalid, in_bresp, in_bid);
      end
      @(negedge clock);
      out_bvalid = 1'b0; out_bresp = 2'b00;
   endtask

   task automatic test_concurrent();
      @(negedge clock);
      in_arvalid = 1'b1; in_arid = 4'd9; in_araddr = 32'h20; in_arlen = 8'd0;
      in_arsize = 3'd2; in_arburst = 2'b01;
      in_awvalid = 1'b1; in_awid = 4'd6; in_awaddr = 32'h24; in_awlen = 8'd0;
      in_awsize = 3'd2; in_awburst = 2'b01;
      #1;
      checks++;
      if (in_arready !== 1'b1 || in_awready !== 1'b1) begin
         errors++;
         $display("FAIL concurrent_accept: arready=%b awready=%b expected 1 1", in_arready, in_awready);
      end
      // Stall cycle 1: grant AW only.
      @(negedge clock);
      in_arvalid = 1'b0; in_awvalid = 1'b0; out_awready = 1'b1; out_arready = 1'b0;
      #1;
      checks++;
      if (out_arvalid !== 1'b1 || out_awvalid !== 1'b1 || out_arid !== 4'd9 || out_awid !== 4'd6) begin
         errors++;
         $display("FAIL concurrent_issue: arvalid=%b awvalid=%b arid=%h awid=%h expected 1 1 9 6",
                  out_arvalid, out_awvalid, out_arid, out_awid);
      end
      // Stall cycle 2: write data beat.
      @(negedge clock);
      out_awready = 1'b0;
      in_wvalid = 1'b1; in_wdata = 32'h1234_5678; in_wstrb = 4'h3; in_wlast = 1'b1; out_wready = 1'b1;
      #1;
      checks++;
      if (in_wready !== 1'b1 || out_wstrb !== 8'h30 || out_arvalid !== 1'b1) begin
         errors++;
         $display("FAIL concurrent_w: wready=%b strb=%h arvalid=%b expected 1 30 1",
                  in_wready, out_wstrb, out_arvalid);
      end
      // Stall cycle 3: write response.
      @(negedge clock);
      in_wvalid = 1'b0; in_wlast = 1'b0; out_wready = 1'b0;
      out_bvalid = 1'b1; out_bid = 4'd6; out_bresp = 2'b00; in_bready = 1'b1;
      #1;
      checks++;
      if (in_bvalid !== 1'b1 || in_bid !== 4'd6) begin
         errors++;
         $display("FAIL concurrent_b: bvalid=%b bid=%h expected 1 6", in_bvalid, in_bid);
      end
      // Stall cycles 4 and 5: write is done, read still waiting.
      for (int s = 0; s < 2; s++) begin
         @(negedge clock);
         out_bvalid = 1'b0;
         #1;
         checks++;
         if (in_awready !== 1'b1 || out_arvalid !== 1'b1 || in_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL concurrent_stall%0d: awready=%b arvalid=%b rvalid=%b expected 1 1 0",
                     s, in_awready, out_arvalid, in_rvalid);
         end
      end
      out_arready = 1'b1;
      @(negedge clock);
      out_arready = 1'b0;
      out_rvalid = 1'b1; out_rid = 4'd9; out_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      out_rlast = 1'b1; in_rready = 1'b1;
      #1;
      checks++;
      if (in_rvalid !== 1'b1 || in_rid !== 4'd9 || in_rdata !== 32'hCCCC_DDDD) begin
         errors++;
         $display("FAIL concurrent_r: rvalid=%b rid=%h data=%h expected 1 9 ccccdddd",
                  in_rvalid, in_rid, in_rdata);
      end
      @(negedge clock);
      out_rvalid = 1'b0; out_rlast = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      issue_ar(4'd2, 32'h0, 8'd7, 3'd2, 2'b01);
      out_rvalid = 1'b1; out_rdata = 64'h0101_0101_0202_0202; out_rlast = 1'b0; in_rready = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (in_rvalid !== 1'b0 || out_arvalid !== 1'b0 || in_arready !== 1'b1 || out_rready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_burst: rvalid=%b arvalid=%b arready=%b rready=%b expected 0 0 1 0",
                  in_rvalid, out_arvalid, in_arready, out_rready);
      end
      @(negedge clock);
      #1;
      checks++;
      if (in_rvalid !== 1'b0 || in_arready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_burst_hold: rvalid=%b arready=%b expected 0 1", in_rvalid, in_arready);
      end
      reset = 1'b1; out_rvalid = 1'b0;
      // Fresh read after reset; oversized arsize is clamped to 4 bytes.
      issue_ar(4'd7, 32'h4, 8'd0, 3'd3, 2'b01);
      checks++;
      if (out_arsize !== 3'd2 || out_araddr !== 32'h4 || out_arid !== 4'd7) begin
         errors++;
         $display("FAIL fresh_read_ar: size=%h addr=%h id=%h expected 2 00000004 7",
                  out_arsize, out_araddr, out_arid);
      end
      out_rvalid = 1'b1; out_rid = 4'd7; out_rdata = 64'h5555_6666_7777_8888; out_rlast = 1'b1;
      #1;
      checks++;
      if (in_rvalid !== 1'b1 || in_rdata !== 32'h5555_6666 || in_rid !== 4'd7 || in_rlast !== 1'b1) begin
         errors++;
         $display("FAIL fresh_read_r: rvalid=%b data=%h rid=%h last=%b expected 1 55556666 7 1",
                  in_rvalid, in_rdata, in_rid, in_rlast);
      end
      @(negedge clock);
      out_rvalid = 1'b0; out_rlast = 1'b0;
      #1;
      checks++;
      if (in_arready !== 1'b1) begin
         errors++;
         $display("FAIL fresh_read_done: in_arready=%b expected 1", in_arready);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_incr_read();
      test_addr_wrap_and_fixed();
      test_single_write();
      test_wrap_write();
      test_concurrent();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4_data_width_converter_32to64.md
Name: axi4_data_width_converter_32to64

Overview:
- AXI4 upsizer: connects a 32-bit AXI4 manager (in_*) to a 64-bit AXI4 subordinate (out_*).
- It is the reverse direction of the existing 64-to-32 downsizer.
- Read and write paths are independent. Each path allows one outstanding transaction and tracks the per-beat address, so narrow beats are steered onto the correct 32-bit lane of the 64-bit bus.
- Sits between the 32-bit core/peripheral crossbar port and 64-bit memory-side slaves.

Parameters:
ID_W, 4, AXI ID width on both sides
ADDR_W, 32, address width on both sides

Ports:
clock  input  1  sole clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
in_arvalid/in_arready  input/output  1/1  read-address handshake, 32-bit side
in_arid/in_araddr/in_arlen/in_arsize/in_arburst  input  ID_W/ADDR_W/8/3/2  read-address payload
in_rvalid/in_rready  output/input  1/1  read-data handshake
in_rid/in_rdata/in_rresp/in_rlast  output  ID_W/32/2/1  read-data payload
in_awvalid/in_awready  input/output  1/1  write-address handshake
in_awid/in_awaddr/in_awlen/in_awsize/in_awburst  input  ID_W/ADDR_W/8/3/2  write-address payload
in_wvalid/in_wready  input/output  1/1  write-data handshake
in_wdata/in_wstrb/in_wlast  input  32/4/1  write-data payload
in_bvalid/in_bready  output/input  1/1  write-response handshake
in_bid/in_bresp  output  ID_W/2  write-response payload
out_ar*, out_r*, out_aw*, out_w*, out_b*  mirror of the in_* set, opposite direction, 64-bit side
out_rdata  input  64  read data, 64-bit side
out_wdata  output  64  write data, 64-bit side
out_wstrb  output  8  write strobes, 64-bit side

Behaviour:
Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
- R_IDLE: in_arready=1. On in_arvalid, capture id, addr, len, burst, and size (size clamped to min(size,2)); go to R_ADDR.
- R_ADDR: out_arvalid=1 with captured fields unchanged (addr, len, size, burst, id). Go to R_DATA on out_arready.
- R_DATA:
  - Handshake pass-through: in_rvalid=out_rvalid, out_rready=in_rready.
  - in_rid, in_rresp, in_rlast pass through from the 64-bit side.
  - in_rdata = beat_addr[2] ? out_rdata[63:32] : out_rdata[31:0].
  - On each R handshake, update beat_addr:
    - INCR: += (1<<size).
    - FIXED: unchanged.
    - WRAP: increments within the aligned window of (len+1)<<size bytes.
  - Handshake with out_rlast=1 -> R_IDLE.

Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
- W_IDLE and W_ADDR: same capture/issue scheme as the read FSM, using AW signals.
- W_DATA:
  - in_wready=out_wready, out_wvalid=in_wvalid.
  - out_wdata={in_wdata,in_wdata}.
  - out_wstrb = beat_addr[2] ? {in_wstrb,4'b0} : {4'b0,in_wstrb}.
  - out_wlast=in_wlast; beat_addr updates as for reads.
  - Handshake with in_wlast=1 -> W_RESP.
- W_RESP: B channel pass-through; on B handshake -> W_IDLE.
- in_wready=0 outside W_DATA, so W beats arriving before AW are stalled (legal AXI).

Timing and reset:
- Address latency: 1 cycle (capture) plus the slave's arready/awready delay.
- Data and response channels add zero latency (combinational).
- Reset values: all valid/ready outputs 0 except in_arready=1 and in_awready=1 (IDLE). All payload outputs and registers 0.
- Reset asserted mid-burst: both FSMs return to IDLE immediately. No completion is generated for the aborted burst.

Edge cases:
- Simultaneous AR and AW: accepted in the same cycle; paths are independent.
- A new AR arriving while a read is active is held off (in_arready=0) until rlast completes. Same for AW until the B handshake.
- Unaligned start address: lane is selected by addr[2] of each beat; the address is forwarded unmodified.
- Address wrap at 2^ADDR_W: INCR beat_addr wraps modulo 2^ADDR_W.

Optional Feature:
AXI4_UPSIZER_ZERO_FILL_EN
- Defined: the inactive 32-bit half of out_wdata is driven to 0 instead of a replica.
- Undefined: both halves carry in_wdata (replication).
- Strobes and read behaviour are identical either way.

Test Plan:
1. Single read, araddr=0x8000_0004, size=2, out_rdata=0x1111_2222_3333_4444 -> in_rdata=0x1111_2222, in_rlast=1, out_araddr=0x8000_0004.
2. INCR read, len=3, size=2, addr=0x0 -> lanes low, high, low, high across beats; rlast on beat 4 only; the next AR is accepted only after that.
3. Single write, awaddr=0x10, wdata=0xDEAD_BEEF, wstrb=0xF -> out_wstrb=0x0F, out_wdata low half 0xDEAD_BEEF. Repeat at 0x14 -> out_wstrb=0xF0. Check the inactive half with the macro on (0) and off (replica).
4. WRAP write, len=3, size=2, addr=0x18 -> beat addrs 0x18, 0x1C, 0x10, 0x14 -> strobes 0x0F, 0xF0, 0x0F, 0xF0; bresp=2'b10 from the slave reaches in_bresp.
5. Concurrent AR+AW in the same cycle, with the slave stalling arready for 5 cycles -> write completes independently; read is issued after the stall; IDs are preserved.
6. reset low during beat 2 of a len=7 read -> next cycle in_rvalid=0, out_arvalid=0, in_arready=1; after release, a fresh read completes correctly.
